// File: rtl/mips_muldiv.sv
// Multiply/divide unit with private HI/LO registers for the MIPS execute stage.
// Multiplies commit after MUL_LATENCY cycles; divides run WIDTH restoring steps plus one sign fix-up cycle.
//
// state  | meaning
// S_IDLE | no op in flight; accepts mul/div/mthi/mtlo
// S_MUL  | multiply in flight, counting down to commit
// S_DIV  | restoring divide, one quotient bit per cycle, MSB first
// S_FIX  | apply result signs / special cases, commit at end of cycle
module mips_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_signed;
  logic             r_sa;
  logic             r_sb;
  logic             r_busy;
  logic             r_done;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_mt;
  logic             w_accept;
  logic             w_commit_mul;
  logic             w_commit_div;

  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign w_is_mt  = (i_op == OP_MTHI) || (i_op == OP_MTLO);
  assign w_accept = i_start && !i_flush && (r_state == S_IDLE) &&
                    (w_is_mul || w_is_div || w_is_mt);

  // Extending both operands to 2*WIDTH makes one multiplier serve both signednesses.
  assign w_mul_a = r_signed ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
  assign w_mul_b = r_signed ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_sa    = (i_op == OP_DIV) && i_a[WIDTH-1];
  assign w_sb    = (i_op == OP_DIV) && i_b[WIDTH-1];
  assign w_abs_a = w_sa ? -i_a : i_a;
  assign w_abs_b = w_sb ? -i_b : i_b;

  // The remainder is always below the divisor, so a borrow in bit WIDTH means "does not fit".
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_ge    = !w_diff[WIDTH];

  assign w_q_fix = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_r_fix = r_sa ? -r_rem : r_rem;

  always_comb begin
    w_next       = r_state;
    w_commit_mul = 1'b0;
    w_commit_div = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL: begin
        if (i_flush) begin
          w_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_next       = S_IDLE;
          w_commit_mul = 1'b1;
        end
      end
      S_DIV: begin
        if (i_flush)             w_next = S_IDLE;
        else if (r_cnt == '0)    w_next = S_FIX;
      end
      S_FIX: begin
        w_next       = S_IDLE;
        w_commit_div = !i_flush;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= w_commit_mul || w_commit_div;

      if (w_accept) begin
        case (i_op)
          OP_MTHI: r_hi <= i_a;
          OP_MTLO: r_lo <= i_a;
          OP_MULT, OP_MULTU: begin
            r_opa    <= i_a;
            r_opb    <= i_b;
            r_signed <= (i_op == OP_MULT);
            r_cnt    <= CW'(MUL_LATENCY - 1);
          end
          OP_DIV, OP_DIVU: begin
            r_opa <= i_a;
            r_opb <= w_abs_b;
            r_quo <= w_abs_a;
            r_rem <= '0;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_cnt <= CW'(WIDTH - 1);
          end
          default: ;
        endcase
      end else begin
        if (r_state == S_DIV) begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end
        if ((r_state == S_MUL || r_state == S_DIV) && r_cnt != '0)
          r_cnt <= r_cnt - CW'(1);
      end

      if (w_commit_mul) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end

      // A zero divisor leaves the raw dividend in HI and all ones in LO.
      if (w_commit_div) begin
        if (r_opb == '0) begin
          r_hi <= r_opa;
          r_lo <= '1;
        end else begin
          r_hi <= w_r_fix;
          r_lo <= w_q_fix;
        end
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected HI/LO pushed at issue, popped and compared on each done pulse.
module tb_mips_muldiv;
  localparam int W  = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  mips_muldiv #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference model from the arithmetic rules, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    p  = '0;
    case (o)
      3'b001: p = sx * sy;
      3'b010: p = ux * uy;
      3'b011: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      3'b100: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          p  = {ur[31:0], uq[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no commit", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_hilo", {hi, lo}, mon_e);
      end
    end
  end

  // Issues one op from idle and measures how many cycles busy stays high.
  // With poke set, a stray MULT start is driven while the op is in flight.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name, input bit poke);
    int n;
    int c;
    int expb;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check({name, "_idle_timeout"}, 64'(busy), 64'd0);
    expb = (o == 3'b001 || o == 3'b010) ? ML : ((o == 3'b011 || o == 3'b100) ? W + 1 : 0);
    op = o; a = x; b = y; start = 1'b1;
    if (expb != 0) exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      c++;
      if (poke && c == 5) begin
        start = 1'b1; op = 3'b001; a = $urandom; b = $urandom;
      end else if (poke && c == 6) begin
        start = 1'b0; op = 3'b000;
      end
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(c), 64'(expb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b001, 32'hFFFF_FFFF, 32'h2, "mult", 1'b0);
    check("mult_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(3'b010, 32'hFFFF_FFFF, 32'h2, "multu", 1'b0);
    check("multu_vec", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    issue(3'b100, 32'd100, 32'd7, "divu", 1'b0);
    check("divu_vec", {hi, lo}, {32'd2, 32'd14});
    issue(3'b011, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0);
    check("div_neg_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    check("div_ovf_vec", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(3'b011, 32'h1234_5678, 32'd0, "div_zero", 1'b0);
    check("div_zero_vec", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    issue(3'b100, 32'h8765_4321, 32'd0, "divu_zero", 1'b0);
    check("divu_zero_vec", {hi, lo}, 64'h8765_4321_FFFF_FFFF);

    // Back-to-back: second op accepted the cycle after the first commits.
    issue(3'b001, 32'hFFFF_FFF0, 32'd3, "b2b_mult", 1'b0);
    issue(3'b100, 32'd1000, 32'd33, "b2b_divu", 1'b0);
    check("b2b_vec", {hi, lo}, {32'd10, 32'd30});

    issue(3'b100, 32'd555, 32'd10, "start_busy", 1'b1);
    check("start_busy_vec", {hi, lo}, {32'd5, 32'd55});

    // MTHI/MTLO preload, then flush a divide mid-flight.
    issue(3'b101, 32'h0000_AAAA, 32'd0, "mthi", 1'b0);
    check("mthi_vec", {hi, lo}, {32'h0000_AAAA, 32'd55});
    issue(3'b110, 32'h0000_5555, 32'd0, "mtlo", 1'b0);
    check("mtlo_vec", {hi, lo}, 64'h0000_AAAA_0000_5555);

    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, 64'h0000_AAAA_0000_5555);
    repeat (40) @(negedge clk);
    check("flush_after_hilo", {hi, lo}, 64'h0000_AAAA_0000_5555);

    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("start_flush_busy", 64'(busy), 64'd0);
    op = 3'b101; a = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'b000;
    @(negedge clk);
    check("mthi_flush_hilo", {hi, lo}, 64'h0000_AAAA_0000_5555);
    repeat (40) @(negedge clk);
    check("start_flush_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of a divide aborts it without committing.
    op = 3'b100; a = 32'd99; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_hilo", {hi, lo}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(1, 4));
      issue(ro, pick(), pick(), "rand", 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised multiply/divide unit with private HI/LO registers for the pipelined MIPS core, driven from the execute stage. Multiplies run in a fixed-depth pipeline. Divides run as a radix-2 iterative sequence. While an operation is in flight the unit raises `busy`, which the hazard unit uses to stall any instruction that issues a new mul/div or reads HI/LO. A `flush` input abandons in-flight work when the owning instruction is squashed.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be even and ≥ 4.
- `MUL_LATENCY`, default 2: multiply cycles from accept to commit; range 1..4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request from execute stage; sampled each rising edge.
- `op` input 3: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000 and 111 are no-op.
- `a` input WIDTH: rs operand (dividend / multiplicand / MTHI or MTLO source).
- `b` input WIDTH: rt operand (divisor / multiplier).
- `flush` input 1: abandon in-flight op; also blocks a same-cycle `start`.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.
- `busy` output 1: registered; high while an op is in flight.
- `done` output 1: registered; one-cycle pulse when a mul/div result commits to HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **Accept condition:** `start` and a valid op and `!busy` and `!flush`.
  - `start` while `busy` is ignored; the hazard unit guarantees this does not happen.
  - No-op codes are ignored.
- **MTHI/MTLO** (from IDLE only): `hi` or `lo` takes `a` at the accepting edge. State stays IDLE; no `busy`, no `done`.
- **MULT/MULTU:**
  - Operands are latched at accept; state goes to MUL with a counter.
  - Product is 2·WIDTH bits, signed for MULT, unsigned for MULTU.
  - Commit: {`hi`,`lo`} ← product.
- **DIV/DIVU:**
  - At accept, latch |a| and |b| (signed) or a and b (unsigned), plus the two sign bits; state goes to DIV.
  - DIV runs WIDTH restoring iterations, one quotient bit per cycle, MSB first.
  - Then FIX for one cycle: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. Commit at the end of FIX.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Result: `lo` ← quotient, `hi` ← remainder.
- **Divide by zero:** latency is unchanged; `lo` ← all ones and `hi` ← `a` (as latched), for both DIV and DIVU.
- **Signed overflow** (DIV of most-negative value by −1): `lo` ← most-negative value, `hi` ← 0.
- **`flush`** in any non-IDLE state: next state is IDLE, `busy` goes to 0, `hi`/`lo` are unchanged, no `done`. `flush` in IDLE has no effect.
- **`rst`:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE. Reset overrides `start` and `flush`, and aborts any in-flight op without committing.

## Timing
- Accept at edge T0. `busy`=1 from after T0 until the commit edge.
- **Multiply:** commit at edge T0+MUL_LATENCY. `busy` is high for MUL_LATENCY cycles.
- **Divide:** commit at edge T0+WIDTH+1. `busy` is high for WIDTH+1 cycles (33 when WIDTH=32).
- **At the commit edge:**
  - `hi`/`lo` update.
  - `busy` falls to 0.
  - `done` rises to 1 for exactly one cycle.
- Back-to-back ops: a new op may be accepted in the cycle after commit, when `busy`=0.
- `hi`/`lo` read during `busy` return the old values. The hazard unit stalls MFHI/MFLO while `busy`=1.
- MTHI/MTLO: the value is visible on `hi`/`lo` the cycle after the accepting edge.
- `flush` and commit due on the same edge: flush wins, no commit and no `done`.

## Test plan
- **Reset:** assert `rst` for 2 cycles, including mid-divide → `hi`=`lo`=0, `busy`=0, `done`=0; no commit afterwards.
- **Multiply, WIDTH=32, MUL_LATENCY=2,** `a`=0xFFFFFFFF, `b`=0x00000002:
  - MULT → after 2 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done` pulses once.
  - MULTU → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Divide:**
  - DIVU 100/7 → `busy` high exactly 33 cycles, then `lo`=14, `hi`=2.
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV 0x12345678/0 → after 33 cycles `lo`=0xFFFFFFFF, `hi`=0x12345678.
- **Flush:**
  - Preload with MTHI 0xAAAA, MTLO 0x5555 → values visible on the next cycle with no `busy`.
  - Start DIVU and assert `flush` at cycle 10 → `busy`=0 next cycle, `hi`/`lo` stay 0xAAAA/0x5555, no `done`.
  - `start` and `flush` in the same cycle → nothing accepted.
- **Back-to-back and start-while-busy:** MULT then DIVU issued the cycle after `done` → both results commit in order. A `start` asserted while `busy` is ignored; the in-flight result is unaffected.
